dual_slope_ctrl: RTL and testbench

Dual-slope conversion sequencer for the voltmeter front end: it drives the analog switch selects (auto-zero, input, positive/negative reference) and times each phase with a cycle counter. It consumes the cleaned comparator level produced by the synchronizer/hysteresis filter stage directly upstream. De-integration time is delivered as the conversion result, with polarity and overrange, over a valid/ready handshake.

---
 rtl/dual_slope_pkg.sv | 24 ++
 rtl/phase_timer.sv | 28 ++
 rtl/dual_slope_ctrl.sv | 149 ++++++++++++++
 tb/tb_dual_slope_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/dual_slope_pkg.sv
// rtl/dual_slope_pkg.sv - shared types and constants for the dual-slope sequencer
package dual_slope_pkg;

  typedef enum logic [1:0] {
    IDLE,
    AZ,
    INT,
    DEINT
  } state_t;

  // One-hot switch selects: {refn, refp, in, az}
  typedef logic [3:0] sw_t;
  localparam sw_t SW_OFF  = 4'b0000;
  localparam sw_t SW_AZ   = 4'b0001;
  localparam sw_t SW_IN   = 4'b0010;
  localparam sw_t SW_REFP = 4'b0100;
  localparam sw_t SW_REFN = 4'b1000;

  localparam int unsigned DEF_CNT_WIDTH  = 16;
  localparam int unsigned DEF_AZ_CYCLES  = 1000;
  localparam int unsigned DEF_INT_CYCLES = 10000;
  localparam int unsigned DEF_MAX_DEINT  = 20000;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable up/down phase counter with terminal-count flag
module phase_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= up ? count + 1'b1 : count - 1'b1;
    end
  end

  assign tc = (count == term);

endmodule

// File: rtl/dual_slope_ctrl.sv
// rtl/dual_slope_ctrl.sv - dual-slope conversion sequencer; DUAL_SLOPE_AUTOZERO_EN builds the auto-zero phase
module dual_slope_ctrl
  import dual_slope_pkg::*;
#(
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int unsigned AZ_CYCLES  = DEF_AZ_CYCLES,
  parameter int unsigned INT_CYCLES = DEF_INT_CYCLES,
  parameter int unsigned MAX_DEINT  = DEF_MAX_DEINT
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 cmp_i,
  output logic                 sw_az_o,
  output logic                 sw_in_o,
  output logic                 sw_refp_o,
  output logic                 sw_refn_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] result_o,
  output logic                 polarity_o,
  output logic                 overrange_o,
  output logic                 result_valid_o,
  input  logic                 result_ready_i
);

`ifdef DUAL_SLOPE_AUTOZERO_EN
  localparam bit AUTOZERO = 1'b1;
`else
  localparam bit AUTOZERO = 1'b0;
`endif

  localparam logic [CNT_WIDTH-1:0] INT_LOAD   = CNT_WIDTH'(INT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] FIRST_LOAD = AUTOZERO ? CNT_WIDTH'(AZ_CYCLES - 1) : INT_LOAD;
  localparam logic [CNT_WIDTH-1:0] DEINT_TERM = CNT_WIDTH'(MAX_DEINT - 1);
  localparam state_t               FIRST_ST   = AUTOZERO ? AZ : INT;
  localparam sw_t                  FIRST_SW   = AUTOZERO ? SW_AZ : SW_IN;

  state_t               state;
  sw_t                  sw_q;
  logic                 pol;
  logic                 reg_free;
  logic                 t_load, t_en, t_up, t_tc;
  logic [CNT_WIDTH-1:0] t_val, t_term, count;

  assign reg_free = !result_valid_o || result_ready_i;

  // Phases count down to 0; DEINT counts up from 0 while the integrator has not crossed.
  always_comb begin
    t_load = 1'b0;
    t_val  = '0;
    t_en   = 1'b0;
    t_up   = 1'b0;
    t_term = '0;
    case (state)
      IDLE: begin
        t_load = start_i && reg_free;
        t_val  = FIRST_LOAD;
      end
      AZ: begin
        t_en   = 1'b1;
        t_load = t_tc;
        t_val  = INT_LOAD;
      end
      INT: begin
        t_en   = 1'b1;
        t_load = t_tc;
      end
      DEINT: begin
        t_up   = 1'b1;
        t_term = DEINT_TERM;
        t_en   = (cmp_i == pol);
      end
      default: ;
    endcase
  end

  phase_timer #(.WIDTH(CNT_WIDTH)) u_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load     (t_load),
    .load_val (t_val),
    .en       (t_en),
    .up       (t_up),
    .term     (t_term),
    .count    (count),
    .tc       (t_tc)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      sw_q           <= SW_OFF;
      busy_o         <= 1'b0;
      pol            <= 1'b0;
      result_o       <= '0;
      polarity_o     <= 1'b0;
      overrange_o    <= 1'b0;
      result_valid_o <= 1'b0;
    end else begin
      if (result_valid_o && result_ready_i) result_valid_o <= 1'b0;
      if (abort_i) begin
        state  <= IDLE;
        sw_q   <= SW_OFF;
        busy_o <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start_i && reg_free) begin
            state  <= FIRST_ST;
            sw_q   <= FIRST_SW;
            busy_o <= 1'b1;
          end
`ifdef DUAL_SLOPE_AUTOZERO_EN
          AZ: if (t_tc) begin
            state <= INT;
            sw_q  <= SW_IN;
          end
`endif
          INT: if (t_tc) begin
            state <= DEINT;
            pol   <= cmp_i;
            sw_q  <= cmp_i ? SW_REFN : SW_REFP;
          end
          // A crossing in the timeout cycle still reports the measured count.
          DEINT: if ((cmp_i != pol) || t_tc) begin
            state          <= IDLE;
            sw_q           <= SW_OFF;
            busy_o         <= 1'b0;
            polarity_o     <= pol;
            overrange_o    <= (cmp_i == pol);
            result_o       <= (cmp_i != pol) ? count : CNT_WIDTH'(MAX_DEINT);
            result_valid_o <= 1'b1;
          end
          default: begin
            state  <= IDLE;
            sw_q   <= SW_OFF;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sw_az_o   = AUTOZERO && sw_q[0];
  assign sw_in_o   = sw_q[1];
  assign sw_refp_o = sw_q[2];
  assign sw_refn_o = sw_q[3];

endmodule

// File: tb/tb_dual_slope_ctrl.sv
// tb/tb_dual_slope_ctrl.sv - directed self-checking bench for dual_slope_ctrl
module tb_dual_slope_ctrl;

  localparam int AZC  = 4;
  localparam int INTC = 16;
  localparam int MAXD = 32;
`ifdef DUAL_SLOPE_AUTOZERO_EN
  localparam int AZE = AZC;
`else
  localparam int AZE = 0;
`endif
  localparam logic [3:0] FIRST_SW = (AZE > 0) ? 4'b0001 : 4'b0010;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, abort = 1'b0, cmp = 1'b0, ready = 1'b0;
  logic sw_az, sw_in, sw_refp, sw_refn, busy, polarity, overrange, valid;
  logic [15:0] result;
  logic [3:0] sw;
  int total = 0, bad = 0;

  assign sw = {sw_refn, sw_refp, sw_in, sw_az};
  always #5 clk = ~clk;

  dual_slope_ctrl #(
    .CNT_WIDTH(16), .AZ_CYCLES(AZC), .INT_CYCLES(INTC), .MAX_DEINT(MAXD)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .cmp_i(cmp),
    .sw_az_o(sw_az), .sw_in_o(sw_in), .sw_refp_o(sw_refp), .sw_refn_o(sw_refn),
    .busy_o(busy), .result_o(result), .polarity_o(polarity), .overrange_o(overrange),
    .result_valid_o(valid), .result_ready_i(ready)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Starts a conversion and walks AZ/INT, leaving the bench in DEINT cycle 0.
  task automatic go_to_deint(input logic lvl);
    int errs;
    start = 1'b1; cmp = lvl;
    step;
    start = 1'b0;
    errs = 0;
    for (int i = 0; i < AZE; i++) begin
      if (sw !== 4'b0001 || busy !== 1'b1) errs++;
      step;
    end
    for (int i = 0; i < INTC; i++) begin
      if (sw !== 4'b0010 || busy !== 1'b1) errs++;
      step;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL pre_deint_phases: bad_cycles=%0d required=0", errs); end
    total++; if (sw !== (lvl ? 4'b1000 : 4'b0100)) begin bad++; $display("FAIL deint_entry_sw: got=%b required=%b", sw, lvl ? 4'b1000 : 4'b0100); end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    total++; if (sw !== 4'b0000) begin bad++; $display("FAIL reset_sw: got=%b required=0000", sw); end
    total++; if (busy !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL reset_busy_valid: got=%b%b required=00", busy, valid); end
    total++; if (result !== 16'd0 || polarity !== 1'b0 || overrange !== 1'b0) begin bad++; $display("FAIL reset_result: got=%0d/%b/%b required=0/0/0", result, polarity, overrange); end
    @(negedge clk) rst_n = 1'b1;
    step;
  endtask

  task automatic test_normal;
    int errs;
    ready = 1'b0;
    go_to_deint(1'b1);
    errs = 0;
    for (int k = 0; k <= 10; k++) begin
      if (k == 10) cmp = 1'b0;
      if (sw !== 4'b1000 || valid !== 1'b0 || busy !== 1'b1) errs++;
      step;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL normal_deint_cycles: bad_cycles=%0d required=0", errs); end
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL normal_valid: got=%b required=1", valid); end
    total++; if (result !== 16'd10) begin bad++; $display("FAIL normal_result: got=%0d required=10", result); end
    total++; if (polarity !== 1'b1 || overrange !== 1'b0) begin bad++; $display("FAIL normal_pol_ovr: got=%b%b required=10", polarity, overrange); end
    total++; if (busy !== 1'b0 || sw !== 4'b0000) begin bad++; $display("FAIL normal_idle: busy=%b sw=%b required=0/0000", busy, sw); end
    ready = 1'b1;
    step;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL normal_valid_fall: got=%b required=0", valid); end
  endtask

  task automatic test_overrange;
    int errs;
    go_to_deint(1'b0);
    errs = 0;
    for (int k = 0; k < MAXD; k++) begin
      if (sw !== 4'b0100 || valid !== 1'b0) errs++;
      step;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL ovr_deint_cycles: bad_cycles=%0d required=0", errs); end
    total++; if (valid !== 1'b1 || result !== 16'd32) begin bad++; $display("FAIL ovr_result: valid=%b result=%0d required=1/32", valid, result); end
    total++; if (overrange !== 1'b1 || polarity !== 1'b0) begin bad++; $display("FAIL ovr_flags: ovr=%b pol=%b required=1/0", overrange, polarity); end
    step;
  endtask

  task automatic test_abort;
    int errs;
    go_to_deint(1'b1);
    repeat (5) step;
    total++; if (sw !== 4'b1000) begin bad++; $display("FAIL abort_pre_sw: got=%b required=1000", sw); end
    abort = 1'b1;
    step;
    abort = 1'b0;
    total++; if (busy !== 1'b0 || sw !== 4'b0000) begin bad++; $display("FAIL abort_idle: busy=%b sw=%b required=0/0000", busy, sw); end
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      if (valid !== 1'b0) errs++;
      step;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL abort_no_valid: bad_cycles=%0d required=0", errs); end
    total++; if (result !== 16'd32 || overrange !== 1'b1) begin bad++; $display("FAIL abort_result_kept: result=%0d ovr=%b required=32/1", result, overrange); end
  endtask

  task automatic test_immediate;
    go_to_deint(1'b1);
    cmp = 1'b0;
    step;
    total++; if (valid !== 1'b1 || result !== 16'd0) begin bad++; $display("FAIL imm_result: valid=%b result=%0d required=1/0", valid, result); end
    total++; if (overrange !== 1'b0 || polarity !== 1'b1) begin bad++; $display("FAIL imm_flags: ovr=%b pol=%b required=0/1", overrange, polarity); end
    step;
  endtask

  task automatic test_backpressure;
    int errs;
    ready = 1'b0;
    go_to_deint(1'b1);
    step;
    step;
    cmp = 1'b0;
    step;
    start = 1'b1;
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      if (valid !== 1'b1 || result !== 16'd2 || polarity !== 1'b1 || overrange !== 1'b0) errs++;
      if (busy !== 1'b0 || sw !== 4'b0000) errs++;
      step;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL bp_hold: bad_checks=%0d required=0", errs); end
    ready = 1'b1;
    step;
    start = 1'b0;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL bp_valid_fall: got=%b required=0", valid); end
    total++; if (busy !== 1'b1 || sw !== FIRST_SW) begin bad++; $display("FAIL bp_new_start: busy=%b sw=%b required=1/%b", busy, sw, FIRST_SW); end
    abort = 1'b1;
    step;
    abort = 1'b0;
  endtask

  task automatic test_reset_mid_int;
    ready = 1'b1;
    start = 1'b1; cmp = 1'b1;
    step;
    start = 1'b0;
    repeat (AZE + 5) step;
    total++; if (sw !== 4'b0010 || busy !== 1'b1) begin bad++; $display("FAIL rst_pre_int: sw=%b busy=%b required=0010/1", sw, busy); end
    rst_n = 1'b0;
    #1;
    total++; if (sw !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL rst_async_idle: sw=%b busy=%b required=0000/0", sw, busy); end
    total++; if (valid !== 1'b0 || result !== 16'd0) begin bad++; $display("FAIL rst_async_result: valid=%b result=%0d required=0/0", valid, result); end
    @(negedge clk) rst_n = 1'b1;
    step;
    step;
    total++; if (busy !== 1'b0 || sw !== 4'b0000) begin bad++; $display("FAIL rst_stays_idle: busy=%b sw=%b required=0/0000", busy, sw); end
  endtask

  initial begin
    test_reset;
    test_normal;
    test_overrange;
    test_abort;
    test_immediate;
    test_backpressure;
    test_reset_mid_int;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
